shift_loop_snapshot: RTL and testbench

SHIFT_LOOP_SNAPSHOT -- requirements
Module: shift_loop_snapshot

---
 rtl/shift_loop_snapshot.sv | 140 ++++++++++++++
 tb/tb_shift_loop_snapshot.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_loop_snapshot.sv
// -----------------------------------------------------------------------------
// shift_loop_snapshot
//
// A DEPTH-bit serial shift loop with byte-boundary snapshots and a status byte.
// Every accepted shift pushes one new bit into mem[0], and the bit in
// mem[DEPTH-1] leaves the loop. The new bit comes from the serial input
// (load), from the tail (recirculate) or from the input XOR the tail
// (xor-load).
//
// A 3-bit bit counter and a byte index track progress through the loop. When
// the 8th bit of a byte has been shifted in, the low byte of the updated loop
// is copied into the snapshot register and the valid flag is set. Once set,
// valid stays set until the next reset.
//
// Parameters
//   DEPTH     loop length in bits: 8, 16, 32, 64 or 128
//
// Ports (packed onto two 8-bit buses)
//   io_in[0]    clk    rising-edge clock
//   io_in[1]    rst_n  synchronous reset, active low
//   io_in[2]    din    serial data in
//   io_in[4:3]  mode   00 load, 01 recirculate, 10 hold, 11 xor-load
//   io_in[5]    step   shift enable
//   io_in[6]    osel   0 = snapshot byte, 1 = status byte
//   io_in[7]    clr    synchronous clear of bit_cnt and byte_idx
//   io_out[7:0]        snapshot, or {valid, byte_idx (4 bits), bit_cnt}
// -----------------------------------------------------------------------------
module shift_loop_snapshot #(
    parameter int DEPTH = 64
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int BYTES    = DEPTH / 8;
    localparam int IDXW_RAW = $clog2(BYTES);
    // A single-byte loop still needs a 1-bit index register; it stays at 0.
    localparam int IDXW     = (IDXW_RAW == 0) ? 1 : IDXW_RAW;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_RECIRC = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_XOR   = 2'b11
    } mode_t;

    // Input bus unpacking
    logic  clk;
    logic  rst_n;
    logic  din;
    mode_t mode;
    logic  step;
    logic  osel;
    logic  clr;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign din   = io_in[2];
    assign mode  = mode_t'(io_in[4:3]);
    assign step  = io_in[5];
    assign osel  = io_in[6];
    assign clr   = io_in[7];

    // Architectural state
    logic [DEPTH-1:0] mem;
    logic [7:0]       snap;
    logic             valid;
    logic [2:0]       bit_cnt;
    logic [IDXW-1:0]  byte_idx;

    // Next-cycle helpers
    logic             tail;
    logic             nb;
    logic             shift_en;
    logic             byte_done;
    logic [DEPTH-1:0] mem_next;
    logic [IDXW-1:0]  byte_idx_next;
    logic [3:0]       idx_ext;
    logic [7:0]       status;

    assign tail = mem[DEPTH-1];

    // New-bit selection. Hold never shifts, so its value is irrelevant;
    // it reuses the tail to keep the mux small.
    always_comb begin
        nb = tail;
        unique case (mode)
            MODE_LOAD:   nb = din;
            MODE_RECIRC: nb = tail;
            MODE_XOR:    nb = din ^ tail;
            MODE_HOLD:   nb = tail;
            default:     nb = tail;
        endcase
    end

    // clr takes priority over a step on the same edge, and hold ignores step.
    assign shift_en  = step && !clr && (mode != MODE_HOLD);
    assign byte_done = shift_en && (bit_cnt == 3'd7);
    assign mem_next  = {mem[DEPTH-2:0], nb};

    // BYTES is a power of two, so natural wrap of the index is modulo BYTES,
    // except for the single-byte loop where the index must stay at zero.
    generate
        if (BYTES == 1) begin : g_idx_single
            assign byte_idx_next = '0;
        end else begin : g_idx_multi
            assign byte_idx_next = byte_idx + 1'b1;
        end
    endgenerate

    // Loop, counters, snapshot and valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem      <= '0;
            snap     <= '0;
            valid    <= 1'b0;
            bit_cnt  <= '0;
            byte_idx <= '0;
        end else if (clr) begin
            // Counters restart; the loop contents and last snapshot survive.
            bit_cnt  <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            mem     <= mem_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
                byte_idx <= byte_idx_next;
                // Capture the post-shift low byte so it is a completed byte.
                snap     <= mem_next[7:0];
                valid    <= 1'b1;
            end
        end
    end

    // Output selection, purely combinational from state and osel
    assign idx_ext = 4'(byte_idx);
    assign status  = {valid, idx_ext, bit_cnt};
    assign io_out  = osel ? status : snap;

endmodule

// File: tb/tb_shift_loop_snapshot.sv
// -----------------------------------------------------------------------------
// tb_shift_loop_snapshot
//
// Drives a DEPTH=64 and a DEPTH=16 instance from the same input bus and checks
// both against directed expectations and a history-based reference model.
// The model keeps, per instance, the last DEPTH bits pushed into the loop
// (oldest first) plus a count of shifts since the last clear/reset; counters
// and snapshots are derived from that count with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_shift_loop_snapshot;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic [1:0] mode;
    logic       step;
    logic       osel;
    logic       clr;
    logic [7:0] io_in;
    logic [7:0] out64;
    logic [7:0] out16;

    int checks   = 0;
    int failures = 0;

    assign io_in = {clr, osel, step, mode, din, rst_n, clk};

    shift_loop_snapshot #(.DEPTH(64)) dut64 (.io_in(io_in), .io_out(out64));
    shift_loop_snapshot #(.DEPTH(16)) dut16 (.io_in(io_in), .io_out(out16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit         h64[$];
    bit         h16[$];
    int         nsh;
    logic [7:0] ms64;
    logic [7:0] ms16;
    logic       mvld;

    function automatic logic [7:0] last8_64();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = h64[h64.size()-8+i];
        return b;
    endfunction

    function automatic logic [7:0] last8_16();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = h16[h16.size()-8+i];
        return b;
    endfunction

    function automatic logic [7:0] exp_out(int bytes, logic [7:0] s, logic os);
        logic [3:0] idx;
        logic [2:0] cnt;
        idx = 4'((nsh / 8) % bytes);
        cnt = 3'(nsh % 8);
        return os ? {mvld, idx, cnt} : s;
    endfunction

    task automatic model_edge();
        bit nb64;
        bit nb16;
        if (!rst_n) begin
            h64.delete();
            h16.delete();
            repeat (64) h64.push_back(1'b0);
            repeat (16) h16.push_back(1'b0);
            nsh  = 0;
            ms64 = 8'h00;
            ms16 = 8'h00;
            mvld = 1'b0;
        end else if (clr) begin
            nsh = 0;
        end else if (step && mode != 2'b10) begin
            nb64 = (mode == 2'b00) ? din : (mode == 2'b01) ? h64[0] : (din ^ h64[0]);
            nb16 = (mode == 2'b00) ? din : (mode == 2'b01) ? h16[0] : (din ^ h16[0]);
            h64.push_back(nb64);
            void'(h64.pop_front());
            h16.push_back(nb16);
            void'(h16.pop_front());
            nsh++;
            if (nsh % 8 == 0) begin
                ms64 = last8_64();
                ms16 = last8_16();
                mvld = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_bit(input logic b);
        mode = 2'b00;
        step = 1'b1;
        din  = b;
        tick();
    endtask

    task automatic load_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) load_bit(v[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b1; step = 1'b1; mode = 2'b00; din = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        for (int o = 0; o < 2; o++) begin
            osel = o[0];
            #1;
            checks++;
            if (out64 !== 8'h00) begin
                failures++;
                $display("FAIL reset64 osel=%0d: got %02h expected 00", o, out64);
            end
            checks++;
            if (out16 !== 8'h00) begin
                failures++;
                $display("FAIL reset16 osel=%0d: got %02h expected 00", o, out16);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        logic [7:0] pat;
        pat = 8'hA5;
        do_reset();
        for (int i = 7; i >= 1; i--) load_bit(pat[i]);
        osel = 1'b1; #1;
        checks++;
        if (out64 !== 8'h07 || out16 !== 8'h07) begin
            failures++;
            $display("FAIL status_7bits: got %02h/%02h expected 07", out64, out16);
        end
        load_bit(pat[0]);
        step = 1'b0;
        osel = 1'b1; #1;
        checks++;
        if (out64 !== 8'h88 || out16 !== 8'h88) begin
            failures++;
            $display("FAIL status_byte: got %02h/%02h expected 88", out64, out16);
        end
        osel = 1'b0; #1;
        checks++;
        if (out64 !== 8'hA5 || out16 !== 8'hA5) begin
            failures++;
            $display("FAIL snap_byte: got %02h/%02h expected a5", out64, out16);
        end
    endtask

    task automatic test_load_recirc();
        logic [7:0] e64;
        logic [7:0] e16;
        do_reset();
        for (int v = 1; v <= 8; v++) load_byte(8'(v));
        step = 1'b0;
        osel = 1'b1; #1;
        checks++;
        if (out64 !== 8'h80 || out16 !== 8'h80) begin
            failures++;
            $display("FAIL status_after_load: got %02h/%02h expected 80", out64, out16);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 8; k++) begin
                mode = 2'b01; step = 1'b1; din = 1'($urandom);
                repeat (8) tick();
                step = 1'b0;
                e64 = 8'(k);
                e16 = (k % 2 == 1) ? 8'h07 : 8'h08;
                osel = 1'b0; #1;
                checks++;
                if (out64 !== e64) begin
                    failures++;
                    $display("FAIL recirc64 pass%0d k%0d: got %02h expected %02h", pass, k, out64, e64);
                end
                checks++;
                if (out16 !== e16) begin
                    failures++;
                    $display("FAIL recirc16 pass%0d k%0d: got %02h expected %02h", pass, k, out16, e16);
                end
                osel = 1'b1; #1;
                checks++;
                if (out64 !== {1'b1, 4'(k % 8), 3'b000}) begin
                    failures++;
                    $display("FAIL recirc_status64 k%0d: got %02h expected %02h", k, out64, {1'b1, 4'(k % 8), 3'b000});
                end
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        load_byte(8'hA5);
        mode = 2'b10; step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = 1'($urandom);
            tick();
        end
        step = 1'b0;
        osel = 1'b0; #1;
        checks++;
        if (out64 !== 8'hA5 || out16 !== 8'hA5) begin
            failures++;
            $display("FAIL hold_snap: got %02h/%02h expected a5", out64, out16);
        end
        osel = 1'b1; #1;
        checks++;
        if (out64 !== 8'h88 || out16 !== 8'h88) begin
            failures++;
            $display("FAIL hold_status: got %02h/%02h expected 88", out64, out16);
        end
    endtask

    task automatic test_xor_load();
        logic [7:0] e64;
        do_reset();
        for (int v = 1; v <= 8; v++) load_byte(8'(v));
        mode = 2'b11; din = 1'b1; step = 1'b1;
        repeat (64) tick();
        mode = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            repeat (8) tick();
            e64 = 8'hFF - 8'(k);
            osel = 1'b0; #1;
            checks++;
            if (out64 !== e64) begin
                failures++;
                $display("FAIL xor64 k%0d: got %02h expected %02h", k, out64, e64);
            end
            checks++;
            if (out16 !== ms16) begin
                failures++;
                $display("FAIL xor16 k%0d: got %02h expected %02h", k, out16, ms16);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_clear();
        logic [4:0] part;
        part = 5'b11010;
        do_reset();
        load_byte(8'hA5);
        for (int i = 4; i >= 0; i--) load_bit(part[i]);
        osel = 1'b1; #1;
        checks++;
        if (out64 !== 8'h8D) begin
            failures++;
            $display("FAIL pre_clear_status: got %02h expected 8d", out64);
        end
        clr = 1'b1; step = 1'b1; mode = 2'b00; din = 1'b1;
        tick();
        clr = 1'b0; step = 1'b0;
        osel = 1'b1; #1;
        checks++;
        if (out64 !== 8'h80 || out16 !== 8'h80) begin
            failures++;
            $display("FAIL clear_status: got %02h/%02h expected 80", out64, out16);
        end
        osel = 1'b0; #1;
        checks++;
        if (out64 !== 8'hA5 || out16 !== 8'hA5) begin
            failures++;
            $display("FAIL clear_snap: got %02h/%02h expected a5", out64, out16);
        end
        // Recirculating one full loop exposes whether mem was disturbed.
        mode = 2'b01; step = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            osel = 1'b0; #1;
            checks++;
            if (out64 !== exp_out(8, ms64, 1'b0) || out16 !== exp_out(2, ms16, 1'b0)) begin
                failures++;
                $display("FAIL clear_mem_recirc i%0d: got %02h/%02h expected %02h/%02h",
                         i, out64, out16, exp_out(8, ms64, 1'b0), exp_out(2, ms16, 1'b0));
            end
        end
        // Reset in the middle of a byte
        mode = 2'b00;
        repeat (3) load_bit(1'b1);
        rst_n = 1'b0; step = 1'b1;
        tick();
        rst_n = 1'b1; step = 1'b0;
        for (int o = 0; o < 2; o++) begin
            osel = o[0]; #1;
            checks++;
            if (out64 !== 8'h00 || out16 !== 8'h00) begin
                failures++;
                $display("FAIL midbyte_reset osel=%0d: got %02h/%02h expected 00", o, out64, out16);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            clr   = ($urandom_range(0, 29) == 0);
            step  = ($urandom_range(0, 3) != 0);
            mode  = 2'($urandom_range(0, 3));
            din   = 1'($urandom);
            tick();
            for (int o = 0; o < 2; o++) begin
                osel = o[0]; #1;
                checks++;
                if (out64 !== exp_out(8, ms64, osel)) begin
                    failures++;
                    $display("FAIL random64 c%0d osel=%0d: got %02h expected %02h",
                             c, o, out64, exp_out(8, ms64, osel));
                end
                checks++;
                if (out16 !== exp_out(2, ms16, osel)) begin
                    failures++;
                    $display("FAIL random16 c%0d osel=%0d: got %02h expected %02h",
                             c, o, out16, exp_out(2, ms16, osel));
                end
            end
        end
        rst_n = 1'b1; clr = 1'b0; step = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; din = 1'b0; mode = 2'b00; step = 1'b0; osel = 1'b0; clr = 1'b0;
        test_reset();
        test_single_byte();
        test_load_recirc();
        test_hold();
        test_xor_load();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
